// File: rtl/lsu_ctrl.sv
// Load/store unit between the MEM stage and a word-wide memory with a combinational read.
// It sign/zero-extends loads and uses read-modify-write for SB/SH.
// Macro LSU_MISALIGN_TRAP_EN (optional) turns misaligned halfword/word accesses into errors.
// Word and lane handling assume the RV32 layout (XLEN = 32).
module lsu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, LOAD, RMW, WRITE, RESP} state_t;

    state_t            state_reg;
    logic [2:0]        funct3_reg;
    logic [1:0]        addr_lo_reg;
    logic [15:0]       wdata_lo_reg;
    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic [XLEN-1:0]   resp_rdata_reg;
    logic              resp_err_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic [XLEN-1:0]   mem_addr_reg;
    logic [XLEN-1:0]   mem_wdata_reg;

    logic              req_illegal;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   merged;
    logic [7:0]        rd_lane [4];
    logic [3:0]        lane_en;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign MemRead    = mem_read_reg;
    assign MemWrite   = mem_write_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;

    // Request decode: funct3 legality plus the optional alignment trap.
    always_comb begin
        req_illegal = 1'b0;
        if (req_we)
            req_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
        else
            req_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_illegal = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
            req_illegal = 1'b1;
`endif
    end

    // Byte lanes of the read word; funct3[0] distinguishes SH (halfword lanes) from SB.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign rd_lane[gi] = mem_rdata[8*gi +: 8];
            assign lane_en[gi] = funct3_reg[0] ? (addr_lo_reg[1] == LANE[1])
                                               : (addr_lo_reg == LANE);
            assign merged[8*gi +: 8] = !lane_en[gi] ? rd_lane[gi] :
                                       funct3_reg[0] ? wdata_lo_reg[8*(gi%2) +: 8]
                                                     : wdata_lo_reg[7:0];
        end
        if (XLEN > 32) begin : g_upper
            assign merged[XLEN-1:32] = mem_rdata[XLEN-1:32];
        end
    endgenerate

    always_comb begin
        byte_sel  = rd_lane[addr_lo_reg];
        half_sel  = addr_lo_reg[1] ? {rd_lane[3], rd_lane[2]} : {rd_lane[1], rd_lane[0]};
        load_data = mem_rdata;
        case (funct3_reg)
            F3_B:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            funct3_reg     <= 3'b000;
            addr_lo_reg    <= 2'b00;
            wdata_lo_reg   <= 16'h0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        funct3_reg    <= req_funct3;
                        addr_lo_reg   <= req_addr[1:0];
                        wdata_lo_reg  <= req_wdata[15:0];
                        req_ready_reg <= 1'b0;
                        mem_addr_reg  <= {req_addr[XLEN-1:2], 2'b00};
                        if (req_illegal) begin
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= '0;
                            state_reg      <= RESP;
                        end else if (!req_we) begin
                            mem_read_reg <= 1'b1;
                            state_reg    <= LOAD;
                        end else if (req_funct3[1]) begin
                            // SW: the whole word is the merge word, no read needed.
                            mem_wdata_reg <= req_wdata;
                            mem_write_reg <= 1'b1;
                            state_reg     <= WRITE;
                        end else begin
                            mem_read_reg <= 1'b1;
                            state_reg    <= RMW;
                        end
                    end
                end
                LOAD: begin
                    resp_rdata_reg <= load_data;
                    resp_valid_reg <= 1'b1;
                    mem_read_reg   <= 1'b0;
                    state_reg      <= RESP;
                end
                RMW: begin
                    mem_wdata_reg <= merged;
                    mem_write_reg <= 1'b1;
                    mem_read_reg  <= 1'b0;
                    state_reg     <= WRITE;
                end
                WRITE: begin
                    mem_write_reg  <= 1'b0;
                    mem_wdata_reg  <= '0;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= '0;
                    state_reg      <= RESP;
                end
                RESP: begin
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= '0;
                    mem_addr_reg   <= '0;
                    req_ready_reg  <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: begin
                    req_ready_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: behavioural word memory, response and write scoreboards, per-cycle protocol checks.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic        mem_init;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          started = 1'b0;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h80FF_7F01;
            mem[8]  <= 32'h1122_3344;
            mem[12] <= 32'hCAFE_BABE;
        end else if (MemWrite) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    typedef struct {logic [31:0] rdata; logic err; int lat; int c0;} rexp_t;
    typedef struct {logic [31:0] addr; logic [31:0] data; int cyc;} wexp_t;
    rexp_t rq[$];
    wexp_t wq[$];
    string tq[$];
    rexp_t re;
    wexp_t we_e;
    string cur_tag;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Per-cycle protocol checks and scoreboard popping.
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("rw_excl", {31'b0, MemRead & MemWrite}, 32'h0);
            if (MemRead || MemWrite) chk("addr_align", {30'b0, mem_addr[1:0]}, 32'h0);
            if (req_ready) chk("idle_addr", mem_addr, 32'h0);
            if (!resp_valid) begin
                chk("quiet_rdata", resp_rdata, 32'h0);
                chk("quiet_err", {31'b0, resp_err}, 32'h0);
            end
            if (MemWrite) begin
                if (wq.size() == 0) chk("unexp_write", 32'h1, 32'h0);
                else begin
                    we_e = wq.pop_front();
                    chk("wr_addr", mem_addr, we_e.addr);
                    chk("wr_data", mem_wdata, we_e.data);
                    chk("wr_cyc", cyc, we_e.cyc);
                end
            end
            if (resp_valid) begin
                if (rq.size() == 0) chk("unexp_resp", 32'h1, 32'h0);
                else begin
                    re = rq.pop_front();
                    cur_tag = tq.pop_front();
                    $display("resp %s rdata %h err %b lat %0d", cur_tag, resp_rdata, resp_err, cyc - re.c0);
                    chk({cur_tag, "_rdata"}, resp_rdata, re.rdata);
                    chk({cur_tag, "_err"}, {31'b0, resp_err}, {31'b0, re.err});
                    chk({cur_tag, "_lat"}, cyc - re.c0, re.lat);
                end
            end
        end
    end

    // Called at a negedge; holds the request until accepted, returns at the negedge of cycle 1.
    task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input logic exp_wr, input logic [31:0] wr_addr,
                         input logic [31:0] wr_data, input int wr_lat);
        int waited = 0;
        logic exp_rd1, exp_wr1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            chk({tag, "_accept"}, 32'h0, 32'h1);
            req_valid = 1'b0;
            return;
        end
        rq.push_back('{exp_rdata, exp_err, lat, cyc});
        tq.push_back(tag);
        if (exp_wr) wq.push_back('{wr_addr, wr_data, cyc + wr_lat});
        exp_rd1 = !exp_err && (!we || f3 != 3'b010);
        exp_wr1 = !exp_err && we && f3 == 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_rd1"}, {31'b0, MemRead}, {31'b0, exp_rd1});
        chk({tag, "_wr1"}, {31'b0, MemWrite}, {31'b0, exp_wr1});
    endtask

    task automatic drain();
        int waited = 0;
        while ((rq.size() != 0 || wq.size() != 0) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (rq.size() != 0 || wq.size() != 0) begin
            chk("drain_timeout", 32'h0, 32'h1);
            rq.delete(); wq.delete(); tq.delete();
        end
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_memread", {31'b0, MemRead}, 32'h0);
        chk("rst_memwrite", {31'b0, MemWrite}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0; mem_init = 1'b0; started = 1'b1;
        @(negedge clk);

        // Loads from word 0x10 = 0x80FF7F01; each later request is held through the previous LOAD.
        issue("lb_13",  0, 3'b000, 32'h13, 0, 32'hFFFF_FF80, 0, 2, 0, 0, 0, 0);
        issue("lbu_13", 0, 3'b100, 32'h13, 0, 32'h0000_0080, 0, 2, 0, 0, 0, 0);
        issue("lb_11",  0, 3'b000, 32'h11, 0, 32'h0000_007F, 0, 2, 0, 0, 0, 0);
        issue("lbu_12", 0, 3'b100, 32'h12, 0, 32'h0000_00FF, 0, 2, 0, 0, 0, 0);
        issue("lh_12",  0, 3'b001, 32'h12, 0, 32'hFFFF_80FF, 0, 2, 0, 0, 0, 0);
        issue("lhu_10", 0, 3'b101, 32'h10, 0, 32'h0000_7F01, 0, 2, 0, 0, 0, 0);
        issue("lw_10",  0, 3'b010, 32'h10, 0, 32'h80FF_7F01, 0, 2, 0, 0, 0, 0);
        issue("lh_13",  0, 3'b001, 32'h13, 0, TRAP ? 32'h0 : 32'hFFFF_80FF, TRAP, TRAP ? 1 : 2, 0, 0, 0, 0);

        // Sub-word stores into word 0x20 = 0x11223344, then read back.
        issue("sb_22", 1, 3'b000, 32'h22, 32'h5555_55AB, 32'h0, 0, 3, 1, 32'h20, 32'h11AB_3344, 2);
        issue("sb_21", 1, 3'b000, 32'h21, 32'h0000_00CD, 32'h0, 0, 3, 1, 32'h20, 32'h11AB_CD44, 2);
        issue("lw_20", 0, 3'b010, 32'h20, 0, 32'h11AB_CD44, 0, 2, 0, 0, 0, 0);
        issue("sh_06", 1, 3'b001, 32'h06, 32'h1234_BEEF, 32'h0, 0, 3, 1, 32'h04, 32'hBEEF_0000, 2);
        issue("lh_06", 0, 3'b001, 32'h06, 0, 32'hFFFF_BEEF, 0, 2, 0, 0, 0, 0);
        issue("lhu_06", 0, 3'b101, 32'h06, 0, 32'h0000_BEEF, 0, 2, 0, 0, 0, 0);

        // Word stores and misaligned word accesses.
        issue("sw_08", 1, 3'b010, 32'h08, 32'h1234_5678, 32'h0, 0, 2, 1, 32'h08, 32'h1234_5678, 1);
        issue("lw_08", 0, 3'b010, 32'h08, 0, 32'h1234_5678, 0, 2, 0, 0, 0, 0);
        issue("lw_05", 0, 3'b010, 32'h05, 0, TRAP ? 32'h0 : 32'hBEEF_0000, TRAP, TRAP ? 1 : 2, 0, 0, 0, 0);
        issue("sw_0b", 1, 3'b010, 32'h0B, 32'hA5A5_A5A5, 32'h0, TRAP, TRAP ? 1 : 2, !TRAP, 32'h08, 32'hA5A5_A5A5, 1);
        issue("lw_08b", 0, 3'b010, 32'h08, 0, TRAP ? 32'h1234_5678 : 32'hA5A5_A5A5, 0, 2, 0, 0, 0, 0);

        // Illegal funct3 values.
        issue("ld_f3_3", 0, 3'b011, 32'h10, 0, 32'h0, 1, 1, 0, 0, 0, 0);
        issue("ld_f3_6", 0, 3'b110, 32'h10, 0, 32'h0, 1, 1, 0, 0, 0, 0);
        issue("st_f3_4", 1, 3'b100, 32'h20, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0, 0, 0);
        issue("st_f3_3", 1, 3'b011, 32'h20, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0, 0, 0);
        issue("lb_13b", 0, 3'b000, 32'h13, 0, 32'hFFFF_FF80, 0, 2, 0, 0, 0, 0);
        drain();

        // Reset during the RMW cycle of an SB must abandon the store.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'h0000_0011;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_rmw_rd", {31'b0, MemRead}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_memwrite", {31'b0, MemWrite}, 32'h0);
        chk("rstmid_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rstmid_ready", {31'b0, req_ready}, 32'h1);
        chk("rstmid_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_mem", mem[12], 32'hCAFE_BABE);
        $display("reset-abort sb_31 mem[0x30] %h", mem[12]);

        issue("lbu_31", 0, 3'b100, 32'h31, 0, 32'h0000_00BA, 0, 2, 0, 0, 0, 0);
        drain();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
